// File: rtl/regfile_scoreboard.sv
`default_nettype none
//============================================================================
// Module      : regfile_scoreboard
// Description : Parametrised general-purpose register file with NRD
//               combinational read ports, a writeback port, a dedicated
//               return-address write port, an ALU bypass, and a per-register
//               pending-write scoreboard for RAW hazard detection.
//
// Ports       : clk, rst (sync, active-low)
//               wb_we/wb_addr/wb_data      writeback into the array
//               fwd_valid/fwd_addr/fwd_data ALU bypass (read path only)
//               ra_we/ra_data              return-address register write
//               rd_addr -> rd_data/rd_busy packed read ports
//               issue_valid/issue_addr -> issue_ready  scoreboard increment
//               sb_err                     sticky writeback-underflow flag
//               dbg_sel -> dbg_data        registered debug view of array
// Revision    : 1.0  initial release
//============================================================================
module regfile_scoreboard #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 0,
    parameter int RA_REG   = 13,
    parameter int CNT_W    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_we,
    input  logic [ADDR_W-1:0]     wb_addr,
    input  logic [DATA_W-1:0]     wb_data,
    input  logic                  fwd_valid,
    input  logic [ADDR_W-1:0]     fwd_addr,
    input  logic [DATA_W-1:0]     fwd_data,
    input  logic                  ra_we,
    input  logic [DATA_W-1:0]     ra_data,
    input  logic [NRD*ADDR_W-1:0] rd_addr,
    output logic [NRD*DATA_W-1:0] rd_data,
    output logic [NRD-1:0]        rd_busy,
    input  logic                  issue_valid,
    input  logic [ADDR_W-1:0]     issue_addr,
    output logic                  issue_ready,
    output logic                  sb_err,
    input  logic [ADDR_W-1:0]     dbg_sel,
    output logic [DATA_W-1:0]     dbg_data
);

    localparam int                NREG      = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] c_ZERO    = ADDR_W'(ZERO_REG);
    localparam logic [ADDR_W-1:0] c_RA      = ADDR_W'(RA_REG);
    localparam logic [CNT_W-1:0]  c_CNT_MAX = '1;

    logic [DATA_W-1:0] r_regs [NREG];
    logic [CNT_W-1:0]  r_cnt  [NREG];
    logic [CNT_W-1:0]  w_cnt_nxt [NREG];
    logic              r_sb_err;
    logic              w_err_set;
    logic              w_issue_ready;
    logic [DATA_W-1:0] r_dbg_data;

    // Issue is refused only when the destination counter is already full;
    // the zero register never tracks anything so it is always accepted.
    assign w_issue_ready = !(issue_valid && (issue_addr != c_ZERO) &&
                             (r_cnt[issue_addr] == c_CNT_MAX));
    assign issue_ready   = w_issue_ready;
    assign sb_err        = r_sb_err;
    assign dbg_data      = r_dbg_data;

    //------------------------------------------------------------------------
    // Scoreboard next state
    //------------------------------------------------------------------------
    always_comb begin
        w_err_set = 1'b0;
        for (int r = 0; r < NREG; r++) begin
            w_cnt_nxt[r] = r_cnt[r];
        end
        for (int r = 0; r < NREG; r++) begin
            logic v_inc;
            logic v_dec;
            v_inc = issue_valid && (issue_addr == ADDR_W'(r)) && w_issue_ready;
            v_dec = wb_we && (wb_addr == ADDR_W'(r));
            if (ADDR_W'(r) == c_ZERO) begin
                w_cnt_nxt[r] = '0;
            end else if (v_inc && !v_dec) begin
                w_cnt_nxt[r] = r_cnt[r] + CNT_W'(1);
            end else if (v_dec && !v_inc) begin
                // Writeback with nothing outstanding: hold at zero, flag it.
                if (r_cnt[r] == '0) begin
                    w_err_set = 1'b1;
                end else begin
                    w_cnt_nxt[r] = r_cnt[r] - CNT_W'(1);
                end
            end
        end
    end

    //------------------------------------------------------------------------
    // State registers
    //------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int r = 0; r < NREG; r++) begin
                r_regs[r] <= '0;
                r_cnt[r]  <= '0;
            end
            r_sb_err   <= 1'b0;
            r_dbg_data <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                r_cnt[r] <= w_cnt_nxt[r];
            end
            if (w_err_set) begin
                r_sb_err <= 1'b1;
            end
            if (wb_we && (wb_addr != c_ZERO)) begin
                r_regs[wb_addr] <= wb_data;
            end
            // Placed after the writeback so RA data wins a same-cycle clash.
            if (ra_we && (c_RA != c_ZERO)) begin
                r_regs[c_RA] <= ra_data;
            end
            r_dbg_data <= (dbg_sel == c_ZERO) ? '0 : r_regs[dbg_sel];
        end
    end

    //------------------------------------------------------------------------
    // Read ports: zero reg, then bypass, then RA, then writeback, then array
    //------------------------------------------------------------------------
    for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;
        logic [DATA_W-1:0] w_data;
        logic              w_busy;
        logic              w_fwd_hit;
        logic              w_wb_hit;

        assign w_addr    = rd_addr[gi*ADDR_W +: ADDR_W];
        assign w_fwd_hit = fwd_valid && (fwd_addr == w_addr);
        assign w_wb_hit  = wb_we && (wb_addr == w_addr);

        always_comb begin
            w_data = r_regs[w_addr];
            if (w_addr == c_ZERO) begin
                w_data = '0;
            end else if (w_fwd_hit) begin
                w_data = fwd_data;
            end else if (ra_we && (w_addr == c_RA)) begin
                w_data = ra_data;
            end else if (w_wb_hit) begin
                w_data = wb_data;
            end
        end

        // A pending write is considered resolved when the bypass supplies it
        // or when this cycle's writeback retires the last outstanding write.
        always_comb begin
            w_busy = (r_cnt[w_addr] != '0) && !w_fwd_hit &&
                     !(w_wb_hit && (r_cnt[w_addr] == CNT_W'(1)));
            if (w_addr == c_ZERO) begin
                w_busy = 1'b0;
            end
        end

        assign rd_data[gi*DATA_W +: DATA_W] = w_data;
        assign rd_busy[gi]                  = w_busy;
    end

endmodule
`default_nettype wire
